// File: rtl/mvm_noc_injector.sv
// Packet-level round-robin arbiter sharing one NoC injection port among NREQ AXI-Stream requesters.
// Grants are held until TLAST (or a forced cut at MAXBEATS), and the output is served from a 2-entry skid buffer.
module mvm_noc_injector #(
    parameter int NREQ     = 4,
    parameter int DATAW    = 512,
    parameter int USERW    = 2,
    parameter int DESTW    = 4,
    parameter int MAXBEATS = 64,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAXBEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         s_tvalid,
    output logic [NREQ-1:0]         s_tready,
    input  logic [NREQ*DATAW-1:0]   s_tdata,
    input  logic [NREQ-1:0]         s_tlast,
    input  logic [NREQ*USERW-1:0]   s_tuser,
    input  logic [NREQ*DESTW-1:0]   s_tdest,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATAW-1:0]        m_tdata,
    output logic                    m_tlast,
    output logic [USERW-1:0]        m_tuser,
    output logic [DESTW-1:0]        m_tdest,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    err_overlen
);

    localparam int EW = DATAW + 1 + USERW + DESTW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d, last_grant_q;
    logic [CW-1:0]     cnt_q;
    logic [USERW-1:0]  user_hold_q;
    logic [DESTW-1:0]  dest_hold_q;
    logic              err_q;
    logic [EW-1:0]     ent0_q, ent1_q;
    logic [1:0]        occ_q;

    logic              sel_valid, sel_last;
    logic [DATAW-1:0]  sel_data;
    logic [USERW-1:0]  sel_user;
    logic [DESTW-1:0]  sel_dest;
    logic              arb_hit;
    logic [GW-1:0]     arb_idx, cand;
    logic              full, push, pop, first, forced, tlast_out;
    logic [EW-1:0]     push_ent;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        sel_dest  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DATAW +: DATAW];
                sel_user  = s_tuser[i*USERW +: USERW];
                sel_dest  = s_tdest[i*DESTW +: DESTW];
            end
        end
    end

    // Scanning downward lets the nearest requester after last_grant win the final assignment.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (s_tvalid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign full      = (occ_q == 2'd2);
    assign push      = (state_q == BUSY) && !full && sel_valid;
    assign pop       = (occ_q != 2'd0) && m_tready;
    assign first     = (cnt_q == '0);
    assign forced    = (cnt_q == CW'(MAXBEATS - 1));
    assign tlast_out = sel_last | forced;
    assign push_ent  = {sel_data, tlast_out,
                        first ? sel_user : user_hold_q,
                        first ? sel_dest : dest_hold_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        s_tready = '0;
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    state_d = BUSY;
                    grant_d = arb_idx;
                end
            end
            BUSY: begin
                for (int i = 0; i < NREQ; i++) begin
                    s_tready[i] = !full && (grant_q == GW'(i));
                end
                if (push && tlast_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GW'(NREQ - 1);
            cnt_q        <= '0;
            user_hold_q  <= '0;
            dest_hold_q  <= '0;
            err_q        <= 1'b0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            occ_q        <= 2'd0;
        end else begin
            if (push) begin
                cnt_q <= cnt_q + CW'(1);
                if (first) begin
                    user_hold_q <= sel_user;
                    dest_hold_q <= sel_dest;
                end
                if (forced && !sel_last) begin
                    err_q <= 1'b1;
                end
                if (tlast_out) begin
                    last_grant_q <= grant_q;
                    cnt_q        <= '0;
                end
            end
            // Push is gated by !full, so push+pop only ever happens at occupancy 1.
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_q <= push_ent;
                    else               ent1_q <= push_ent;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: ent0_q <= push_ent;
                default: ;
            endcase
        end
    end

    assign {m_tdata, m_tlast, m_tuser, m_tdest} = ent0_q;
    assign m_tvalid    = (occ_q != 2'd0);
    assign grant_id    = grant_q;
    assign busy        = (state_q == BUSY);
    assign err_overlen = err_q;

endmodule

// File: tb/tb_mvm_noc_injector.sv
// Randomized self-checking bench for mvm_noc_injector against a packet-segment level round-robin model.
module tb_mvm_noc_injector;

    localparam int NREQ     = 4;
    localparam int DATAW    = 16;
    localparam int USERW    = 2;
    localparam int DESTW    = 4;
    localparam int MAXBEATS = 4;
    localparam int GW       = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       s_tvalid;
    logic [NREQ-1:0]       s_tready;
    logic [NREQ*DATAW-1:0] s_tdata;
    logic [NREQ-1:0]       s_tlast;
    logic [NREQ*USERW-1:0] s_tuser;
    logic [NREQ*DESTW-1:0] s_tdest;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [DATAW-1:0]      m_tdata;
    logic                  m_tlast;
    logic [USERW-1:0]      m_tuser;
    logic [DESTW-1:0]      m_tdest;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  err_overlen;

    mvm_noc_injector #(
        .NREQ(NREQ), .DATAW(DATAW), .USERW(USERW), .DESTW(DESTW), .MAXBEATS(MAXBEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdest(m_tdest),
        .grant_id(grant_id), .busy(busy), .err_overlen(err_overlen)
    );

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             last;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
    } beat_t;

    beat_t rq[NREQ][$];
    beat_t cp[NREQ][$];
    beat_t expq[$];
    int    gexp[$];
    int    pos[NREQ];
    int    model_lg;
    bit    exp_err;
    int    errs = 0;
    int    checks = 0;
    int    first_v, first_mv, last_mv, first_acc, last_acc, nacc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t out_beat();
        beat_t b;
        b.data = m_tdata;
        b.last = m_tlast;
        b.user = m_tuser;
        b.dest = m_tdest;
        return b;
    endfunction

    // d1/u1 < 0 means later beats carry random tdest/tuser (which must be ignored).
    task automatic add_pkt(input int r, input int len, input int base,
                           input int d0, input int u0, input int d1, input int u1);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = (base >= 0) ? DATAW'(base + k) : DATAW'($urandom);
            b.last = (k == len - 1);
            b.user = USERW'((k == 0) ? u0 : ((u1 < 0) ? int'($urandom_range(3)) : u1));
            b.dest = DESTW'((k == 0) ? d0 : ((d1 < 0) ? int'($urandom_range(15)) : d1));
            rq[r].push_back(b);
        end
    endtask

    // Output as a sequence of segments: round-robin over non-empty requester queues,
    // each grant carrying at most MAXBEATS beats of the requester's current packet.
    task automatic build_model();
        int r, n;
        bit any, lastout;
        beat_t b, f, e;
        for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (cp[i].size() > 0) any = 1'b1;
            if (any) begin
                r = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (r < 0 && cp[(model_lg + k) % NREQ].size() > 0) r = (model_lg + k) % NREQ;
                gexp.push_back(r);
                f = cp[r][0];
                n = 0;
                lastout = 1'b0;
                while (!lastout) begin
                    b = cp[r].pop_front();
                    n++;
                    lastout = b.last || (n == MAXBEATS);
                    if (lastout && !b.last) exp_err = 1'b1;
                    e.data = b.data;
                    e.last = lastout;
                    e.user = f.user;
                    e.dest = f.dest;
                    expq.push_back(e);
                end
                model_lg = r;
            end
        end
    endtask

    task automatic reset_dut();
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; s_tdest = '0;
        m_tready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst s_tready", 64'(s_tready), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst err_overlen", 64'(err_overlen), 64'(0));
        chk("rst grant_id", 64'(grant_id), 64'(0));
        chk("rst m_payload", 64'(out_beat()), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            pos[i] = 0;
        end
        expq.delete();
        gexp.delete();
        model_lg = NREQ - 1;
        exp_err  = 1'b0;
    endtask

    task automatic run_phase(input string name, input int rdy_pct, input int bub_pct, input int budget);
        int    cyc, occ;
        bit    done, prev_stall, prev_busy, drive;
        beat_t prev_out, b;
        logic [NREQ-1:0] mask;
        build_model();
        first_v = -1; first_mv = -1; last_mv = -1; first_acc = -1; last_acc = -1; nacc = 0;
        cyc = 0; occ = 0; done = 1'b0; prev_stall = 1'b0; prev_busy = busy; prev_out = '0;
        while (!done && cyc < budget) begin
            if (prev_stall) chk({name, " stall hold"}, 64'({m_tvalid, out_beat()}), 64'({1'b1, prev_out}));
            if (busy && !prev_busy) begin
                if (gexp.size() > 0) chk({name, " grant"}, 64'(grant_id), 64'(gexp.pop_front()));
                else chk({name, " unexpected grant"}, 64'(1), 64'(0));
            end
            prev_busy = busy;
            mask = busy ? (NREQ'(1) << grant_id) : '0;
            chk({name, " s_tready select"}, 64'(s_tready & ~mask), 64'(0));
            if (occ == 2) chk({name, " s_tready full"}, 64'(s_tready), 64'(0));
            else if (busy) chk({name, " s_tready open"}, 64'(s_tready[grant_id]), 64'(1));

            m_tready = (rdy_pct < 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                                     : (int'($urandom_range(99)) < rdy_pct);
            for (int i = 0; i < NREQ; i++) begin
                drive = (rq[i].size() > 0) &&
                        !((pos[i] % MAXBEATS) != 0 && int'($urandom_range(99)) < bub_pct);
                b = drive ? rq[i][0] : '0;
                s_tvalid[i] = drive;
                s_tlast[i]  = b.last;
                s_tdata[i*DATAW +: DATAW] = b.data;
                s_tuser[i*USERW +: USERW] = b.user;
                s_tdest[i*DESTW +: DESTW] = b.dest;
            end
            #1;
            if (s_tvalid != '0 && first_v < 0) first_v = cyc;
            for (int i = 0; i < NREQ; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    b = rq[i].pop_front();
                    pos[i] = b.last ? 0 : pos[i] + 1;
                    occ++;
                    nacc++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            if (m_tvalid && first_mv < 0) first_mv = cyc;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = out_beat();
            if (m_tvalid && m_tready) begin
                occ--;
                last_mv = cyc;
                if (expq.size() > 0) chk({name, " beat"}, 64'(out_beat()), 64'(expq.pop_front()));
                else chk({name, " extra beat"}, 64'(1), 64'(0));
            end
            done = (expq.size() == 0);
            for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) done = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid = '0;
        m_tready = 1'b0;
        if (!done) chk({name, " timeout"}, 64'(0), 64'(1));
        chk({name, " err_overlen"}, 64'(err_overlen), 64'(exp_err));
    endtask

    task automatic mid_reset();
        int n, c;
        n = 0;
        c = 0;
        m_tready = 1'b0;
        while (n < 2 && c < 20) begin
            s_tvalid = 4'b0010;
            s_tlast  = '0;
            s_tdata[DATAW +: DATAW] = DATAW'(16'h50 + n);
            s_tdest[DESTW +: DESTW] = 4'd6;
            #1;
            if (s_tready[1]) n++;
            @(posedge clk);
            #1;
            c++;
        end
        chk("midrst beats taken", 64'(n), 64'(2));
        chk("midrst buffered", 64'(m_tvalid), 64'(1));
        reset_dut();
    endtask

    initial begin
        rst = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; s_tdest = '0;
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();

        add_pkt(2, 3, 'hA, 5, 2, 5, 2);
        run_phase("single", 100, 0, 100);
        chk("single latency", 64'(first_mv - first_v), 64'(2));
        chk("single span", 64'(last_mv - first_mv), 64'(2));

        add_pkt(3, 3, -1, 3, 1, 7, 3);
        run_phase("hold", 100, 0, 100);

        add_pkt(1, 6, 'h20, 9, 0, 9, 0);
        run_phase("overlen", 100, 0, 200);
        chk("overlen sticky", 64'(err_overlen), 64'(1));

        add_pkt(0, 8, 'h40, 2, 1, 2, 1);
        run_phase("backpressure", -1, 0, 300);

        mid_reset();

        for (int p = 0; p < 3; p++)
            for (int r = 0; r < NREQ; r++) add_pkt(r, 2, -1, r, r % 4, -1, -1);
        run_phase("rr", 100, 0, 400);
        chk("rr bubbles", 64'(last_acc - first_acc + 1), 64'(nacc + 3 * NREQ - 1));

        for (int ph = 0; ph < 4; ph++) begin
            for (int r = 0; r < NREQ; r++) begin
                int np;
                np = int'($urandom_range(3));
                for (int p = 0; p < np; p++)
                    add_pkt(r, int'($urandom_range(1, 6)), -1, int'($urandom_range(15)),
                            int'($urandom_range(3)), -1, -1);
            end
            run_phase("random", int'($urandom_range(30, 100)), int'($urandom_range(40)), 3000);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mvm_noc_injector.md
# mvm_noc_injector

Packet-level round-robin arbiter that shares one NoC injection port of the MVM mesh among NREQ AXI-Stream requesters (host loader, instruction streamer, MVM result forwarders). Grants are held for a whole packet (until TLAST) so flits of different packets never interleave at a mesh node. TDEST and TUSER are captured on the first beat and held for the packet, since the mesh routes per packet. The output is registered through a 2-entry skid buffer so it can drive the mesh input port directly.

## Interface
- NREQ, 4: number of requesters (2..8).
- DATAW, 512: tdata width per beat.
- USERW, 2: tuser width (AXI-S op code: instruction / reduction / input vector / matrix).
- DESTW, 4: tdest width (mesh node id).
- MAXBEATS, 64: maximum beats per packet before forced termination.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_tvalid  in  NREQ  per-requester valid.
- s_tready  out  NREQ  per-requester ready.
- s_tdata  in  NREQ*DATAW  flattened; requester i occupies bits [i*DATAW +: DATAW].
- s_tlast  in  NREQ  per-requester last.
- s_tuser  in  NREQ*USERW  flattened as tdata.
- s_tdest  in  NREQ*DESTW  flattened as tdata.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready (from mesh).
- m_tdata  out  DATAW  output data.
- m_tlast  out  1  output last (possibly forced).
- m_tuser  out  USERW  packet op code, constant within a packet.
- m_tdest  out  DESTW  packet destination, constant within a packet.
- grant_id  out  clog2(NREQ)  index of the current or most recent grant.
- busy  out  1  high while a packet is granted.
- err_overlen  out  1  sticky; set when a packet is truncated at MAXBEATS.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: all s_tready=0. If any s_tvalid is high, grant the first valid requester searching upward from last_grant+1 (mod NREQ). Register grant_id and go to BUSY next cycle. If no valid, stay in IDLE.
- BUSY:
  - s_tready[grant_id] = skid buffer not full. All other s_tready = 0.
  - An accepted beat pushes {tdata, tlast_out, user_hold, dest_hold} into the skid buffer.
  - user_hold and dest_hold are captured from the first accepted beat of the packet. TUSER and TDEST on later beats are ignored.
- Beat counter, clog2(MAXBEATS+1) bits, increments per accepted beat and clears on leaving BUSY.
- tlast_out = s_tlast OR (count == MAXBEATS-1). If termination is forced and s_tlast=0, set err_overlen. The requester's remaining beats are arbitrated later as a new packet.
- When a beat with tlast_out=1 is accepted: last_grant <= grant_id, go to IDLE.
- Skid buffer: 2 entries; pops when m_tvalid & m_tready. m_* always reflects the head entry.
- Simultaneous push and pop at full occupancy is not possible: ready is derived from "not full", which sustains 1 beat/cycle with 2 entries.
- The skid buffer drains independently of the FSM. A new grant may begin while the previous packet's beats are still buffered; ordering is preserved.
- Reset, asynchronous and clearing immediately:
  - State IDLE; last_grant = NREQ-1, so requester 0 wins first.
  - Buffer empty; m_tvalid=0; m_tdata, m_tlast, m_tuser, m_tdest = 0.
  - s_tready=0, grant_id=0, busy=0, err_overlen=0, beat counter 0.
  - A packet in flight at reset is discarded, including buffered beats.

## Timing
- Arbitration: valid seen in IDLE at cycle t; grant registered and s_tready high at t+1; first beat accepted at t+1; m_tvalid high at t+2 (2-cycle first-beat latency).
- Steady state: 1 beat/cycle while s_tvalid and m_tready are both held high.
- Inter-packet gap: last beat accepted at cycle t, IDLE at t+1, next grant at t+2. This is exactly one bubble cycle on the input side per packet.
- m_tvalid, once high, holds with stable payload until m_tready (AXI-S rule).
- s_tready does not depend combinationally on s_tvalid. s_tready does not depend combinationally on m_tready; it is registered-state driven.
- busy = (state == BUSY). grant_id is stable throughout BUSY.

## Test plan
- Single requester: req 2 sends 3 beats (data 0xA,0xB,0xC, last on 0xC, dest=5, user=2), m_tready=1 → m_tvalid first at cycle t+2; beats appear in order on consecutive cycles; m_tdest=5 and m_tuser=2 on all beats; m_tlast only on 0xC; grant_id=2.
- Round-robin fairness: all 4 requesters continuously send 2-beat packets → grant order 0,1,2,3,0,1…; no interleaving within a packet; 1 input bubble between packets.
- Backpressure: m_tready toggles 1,0,0,1 during an 8-beat packet → no beat lost or duplicated; payload held stable while m_tready=0; s_tready drops within one cycle once 2 entries are buffered.
- Overlength: MAXBEATS=4, requester sends 6 beats with last on beat 6 → output packet 1 is beats 1–4 with m_tlast forced on beat 4; err_overlen=1; beats 5–6 are emitted as a new packet after re-arbitration.
- Dest/user hold: the tdest input changes from 3 to 7 mid-packet → all output beats carry m_tdest=3.
- Reset mid-packet: assert rst after 2 of 5 beats → m_tvalid=0, s_tready=0, busy=0, err_overlen=0 immediately; after release, requester 0 is granted first.
